// File: rtl/heat_pkg.sv
// Shared types and arithmetic helpers for the heat stencil engine.
// Helpers work at a fixed wide width; callers zero-extend TW-bit operands and slice results back.
package heat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_SWAP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ALPHA_HOLD    = 2'd0;
  localparam logic [1:0] ALPHA_HALF    = 2'd1;
  localparam logic [1:0] ALPHA_3QUART  = 2'd2;
  localparam logic [1:0] ALPHA_FULL    = 2'd3;

  // Wide enough for the four-neighbour sum of any TW up to 16.
  localparam int CALC_W = 18;
  typedef logic [CALC_W-1:0] calc_t;

  function automatic calc_t blend(input calc_t t_c, input calc_t sum, input logic [1:0] alpha);
    calc_t avg;
    calc_t res;
    avg = sum >> 2;
    res = t_c;
    case (alpha)
      ALPHA_HOLD:   res = t_c;
      ALPHA_HALF:   res = (t_c + avg) >> 1;
      ALPHA_3QUART: res = (t_c + avg + avg + avg) >> 2;
      ALPHA_FULL:   res = avg;
      default:      res = t_c;
    endcase
    return res;
  endfunction

  function automatic calc_t abs_diff(input calc_t a, input calc_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/heat_stencil_blend.sv
// Combinational stencil cell: neighbour average, alpha blend, fixed-edge override and |delta|.
module heat_stencil_blend
  import heat_pkg::*;
#(
  parameter int TW = 6
) (
  input  logic [TW-1:0] t_c,
  input  logic [TW-1:0] t_l,
  input  logic [TW-1:0] t_r,
  input  logic [TW-1:0] t_u,
  input  logic [TW-1:0] t_d,
  input  logic [1:0]    alpha,
  input  logic          is_edge,
  input  logic [TW-1:0] boundary,
  output logic [TW-1:0] t_new,
  output logic [TW-1:0] delta
);

  calc_t sum;
  calc_t mixed;
  calc_t diff;
  logic [CALC_W-TW-1:0] unused_hi;

  always_comb begin
    sum   = calc_t'(t_l) + calc_t'(t_r) + calc_t'(t_u) + calc_t'(t_d);
    mixed = is_edge ? calc_t'(boundary) : blend(calc_t'(t_c), sum, alpha);
    diff  = abs_diff(mixed, calc_t'(t_c));
  end

  // Every blend result is bounded by the largest operand, so the upper bits are always zero.
  assign t_new     = mixed[TW-1:0];
  assign delta     = diff[TW-1:0];
  assign unused_hi = mixed[CALC_W-1:TW] | diff[CALC_W-1:TW];

endmodule

// File: rtl/heat_stencil_engine.sv
// Jacobi 5-point heat solver over ping-pong banks, with host load/readback and
// a start/done handshake that stops early on the eps convergence criterion.
module heat_stencil_engine
  import heat_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 8,
  parameter int TW     = 6,
  parameter int ITER_W = 8,
  parameter int AW     = $clog2(GRID_W * GRID_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [TW-1:0]     host_wdata,
  output logic [TW-1:0]     host_rdata,
  input  logic              start,
  input  logic [ITER_W-1:0] iterations,
  input  logic [1:0]        alpha,
  input  logic [TW-1:0]     boundary,
  input  logic [TW-1:0]     eps,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] sweep_count,
  output logic [TW-1:0]     max_delta
);

  localparam int N  = GRID_W * GRID_H;
  localparam int XW = $clog2(GRID_W);
  localparam int YW = AW - XW;

  logic [TW-1:0] bank_mem [2][N];

  state_t            state_reg, state_next;
  logic              bank_sel_reg;
  logic [AW-1:0]     idx_reg;
  logic [1:0]        alpha_reg;
  logic [TW-1:0]     boundary_reg;
  logic [TW-1:0]     eps_reg;
  logic [ITER_W-1:0] iter_reg;
  logic [TW-1:0]     run_max_reg;
  logic [ITER_W-1:0] sweep_count_reg;
  logic [TW-1:0]     max_delta_reg;
  logic              converged_reg;
  logic [TW-1:0]     host_rdata_reg;

  logic [XW-1:0]     cell_x;
  logic [YW-1:0]     cell_y;
  logic              is_edge;
  logic [TW-1:0]     t_c, t_l, t_r, t_u, t_d;
  logic [TW-1:0]     t_new, cell_delta;
  logic [ITER_W-1:0] sweep_inc;
  logic              sweep_we, host_ok;

  assign cell_x  = idx_reg[XW-1:0];
  assign cell_y  = idx_reg[AW-1:XW];
  assign is_edge = (cell_x == '0) || (cell_x == XW'(GRID_W - 1)) ||
                   (cell_y == '0) || (cell_y == YW'(GRID_H - 1));

  // Neighbour addresses may wrap for edge cells; those reads are discarded by the edge override.
  assign t_c = bank_mem[bank_sel_reg][idx_reg];
  assign t_l = bank_mem[bank_sel_reg][idx_reg - AW'(1)];
  assign t_r = bank_mem[bank_sel_reg][idx_reg + AW'(1)];
  assign t_u = bank_mem[bank_sel_reg][idx_reg - AW'(GRID_W)];
  assign t_d = bank_mem[bank_sel_reg][idx_reg + AW'(GRID_W)];

  heat_stencil_blend #(.TW(TW)) u_blend (
    .t_c      (t_c),
    .t_l      (t_l),
    .t_r      (t_r),
    .t_u      (t_u),
    .t_d      (t_d),
    .alpha    (alpha_reg),
    .is_edge  (is_edge),
    .boundary (boundary_reg),
    .t_new    (t_new),
    .delta    (cell_delta)
  );

  assign sweep_inc = sweep_count_reg + ITER_W'(1);
  assign sweep_we  = (state_reg == ST_SWEEP);
  assign host_ok   = host_we && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = (iterations == '0) ? ST_DONE : ST_SWEEP;
      end
      ST_SWEEP: begin
        if (idx_reg == AW'(N - 1)) state_next = ST_SWAP;
      end
      ST_SWAP: begin
        if ((run_max_reg <= eps_reg) || (sweep_inc == iter_reg)) state_next = ST_DONE;
        else                                                     state_next = ST_SWEEP;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg         <= '0;
      bank_sel_reg    <= 1'b0;
      alpha_reg       <= '0;
      boundary_reg    <= '0;
      eps_reg         <= '0;
      iter_reg        <= '0;
      run_max_reg     <= '0;
      sweep_count_reg <= '0;
      max_delta_reg   <= '0;
      converged_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            alpha_reg       <= alpha;
            boundary_reg    <= boundary;
            eps_reg         <= eps;
            iter_reg        <= iterations;
            idx_reg         <= '0;
            run_max_reg     <= '0;
            sweep_count_reg <= '0;
            converged_reg   <= 1'b0;
          end
        end
        ST_SWEEP: begin
          idx_reg <= idx_reg + AW'(1);
          if (cell_delta > run_max_reg) run_max_reg <= cell_delta;
        end
        ST_SWAP: begin
          bank_sel_reg    <= ~bank_sel_reg;
          sweep_count_reg <= sweep_inc;
          max_delta_reg   <= run_max_reg;
          run_max_reg     <= '0;
          idx_reg         <= '0;
          if (run_max_reg <= eps_reg) converged_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sweep writes target the inactive bank; host writes only land when no sweep is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank_mem[b][i] <= '0;
        end
      end
    end else if (sweep_we) begin
      bank_mem[~bank_sel_reg][idx_reg] <= t_new;
    end else if (host_ok) begin
      bank_mem[bank_sel_reg][host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_rdata_reg <= '0;
    else        host_rdata_reg <= bank_mem[bank_sel_reg][host_addr];
  end

  assign host_rdata  = host_rdata_reg;
  assign busy        = (state_reg == ST_SWEEP) || (state_reg == ST_SWAP);
  assign done        = (state_reg == ST_DONE);
  assign converged   = converged_reg;
  assign sweep_count = sweep_count_reg;
  assign max_delta   = max_delta_reg;

endmodule

// File: tb/tb_heat_stencil_engine.sv
// Scenario bench for heat_stencil_engine: host reads go through an expectation queue,
// run status is checked inline against a small Jacobi reference model.
module tb_heat_stencil_engine;

  localparam int GRID_W = 8;
  localparam int GRID_H = 8;
  localparam int TW     = 6;
  localparam int ITER_W = 8;
  localparam int N      = GRID_W * GRID_H;
  localparam int AW     = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              host_we;
  logic [AW-1:0]     host_addr;
  logic [TW-1:0]     host_wdata;
  logic [TW-1:0]     host_rdata;
  logic              start;
  logic [ITER_W-1:0] iterations;
  logic [1:0]        alpha;
  logic [TW-1:0]     boundary;
  logic [TW-1:0]     eps;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] sweep_count;
  logic [TW-1:0]     max_delta;

  int    checks = 0;
  int    passes = 0;
  string name_q[$];
  int    exp_q[$];
  int    model[N];
  int    model_max;

  always #5 clk = ~clk;

  heat_stencil_engine #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .TW     (TW),
    .ITER_W (ITER_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .start       (start),
    .iterations  (iterations),
    .alpha       (alpha),
    .boundary    (boundary),
    .eps         (eps),
    .busy        (busy),
    .done        (done),
    .converged   (converged),
    .sweep_count (sweep_count),
    .max_delta   (max_delta)
  );

  task automatic read_cell(input int addr, input int expv, input string tag);
    string t;
    int    e;
    name_q.push_back(tag);
    exp_q.push_back(expv);
    host_addr = AW'(addr);
    @(posedge clk); #1;
    t = name_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    if (host_rdata !== TW'(e)) $display("FAIL %s: host_rdata=%0d expected %0d", t, host_rdata, e);
    else passes++;
  endtask

  task automatic write_cell(input int addr, input int data);
    host_we    = 1'b1;
    host_addr  = AW'(addr);
    host_wdata = TW'(data);
    @(posedge clk); #1;
    host_we    = 1'b0;
  endtask

  task automatic load_model();
    for (int i = 0; i < N; i++) write_cell(i, model[i]);
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < N; i++) read_cell(i, model[i], $sformatf("%s_cell%0d", tag, i));
  endtask

  task automatic model_sweep(input int a, input int b);
    int nxt[N];
    int x, y, c, avg, v, d;
    model_max = 0;
    for (int i = 0; i < N; i++) begin
      x = i % GRID_W;
      y = i / GRID_W;
      c = model[i];
      if (x == 0 || x == GRID_W - 1 || y == 0 || y == GRID_H - 1) begin
        v = b;
      end else begin
        avg = (model[i-1] + model[i+1] + model[i-GRID_W] + model[i+GRID_W]) / 4;
        case (a)
          0:       v = c;
          1:       v = (c + avg) / 2;
          2:       v = (c + 3 * avg) / 4;
          default: v = avg;
        endcase
      end
      d = (v > c) ? v - c : c - v;
      if (d > model_max) model_max = d;
      nxt[i] = v;
    end
    model = nxt;
  endtask

  // Launches a run and returns the start-edge-to-done latency, or -1 on timeout.
  task automatic run(input int iters, input int a, input int b, input int e, output int lat);
    int cyc;
    iterations = ITER_W'(iters);
    alpha      = 2'(a);
    boundary   = TW'(b);
    eps        = TW'(e);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    iterations = ~iterations;
    alpha      = ~alpha;
    boundary   = ~boundary;
    eps        = ~eps;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = (done === 1'b1) ? cyc + 1 : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; start = 1'b0;
    iterations = '0; alpha = '0; boundary = '0; eps = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, converged, sweep_count, max_delta, host_rdata} !== '0)
      $display("FAIL reset_status: busy=%0b done=%0b conv=%0b sweeps=%0d maxd=%0d rdata=%0d required all 0",
               busy, done, converged, sweep_count, max_delta, host_rdata);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      model[i] = 0;
      read_cell(i, 0, $sformatf("reset_cell%0d", i));
    end
  endtask

  task automatic test_single_hot();
    int lat;
    for (int i = 0; i < N; i++) model[i] = 0;
    model[3 * GRID_W + 3] = 63;
    load_model();
    run(1, 3, 0, 0, lat);
    checks++;
    if (lat !== 66) $display("FAIL hot_latency: got %0d required 66", lat); else passes++;
    checks++;
    if (sweep_count !== 8'd1) $display("FAIL hot_sweeps: got %0d required 1", sweep_count); else passes++;
    checks++;
    if (max_delta !== 6'd63) $display("FAIL hot_max_delta: got %0d required 63", max_delta); else passes++;
    checks++;
    if (converged !== 1'b0) $display("FAIL hot_converged: got %0b required 0", converged); else passes++;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) $display("FAIL hot_done_width: done=%0b one cycle later, required 0", done); else passes++;
    model_sweep(3, 0);
    read_cell(3 * GRID_W + 3, 0, "hot_centre");
    read_cell(3 * GRID_W + 2, 15, "hot_left");
    read_cell(3 * GRID_W + 4, 15, "hot_right");
    read_cell(2 * GRID_W + 3, 15, "hot_up");
    read_cell(4 * GRID_W + 3, 15, "hot_down");
    check_model("hot");
  endtask

  task automatic test_uniform();
    int lat;
    for (int i = 0; i < N; i++) model[i] = 20;
    load_model();
    run(10, 2, 20, 0, lat);
    checks++;
    if (lat !== 66) $display("FAIL uni_latency: got %0d required 66", lat); else passes++;
    checks++;
    if (converged !== 1'b1) $display("FAIL uni_converged: got %0b required 1", converged); else passes++;
    checks++;
    if (sweep_count !== 8'd1) $display("FAIL uni_sweeps: got %0d required 1", sweep_count); else passes++;
    checks++;
    if (max_delta !== 6'd0) $display("FAIL uni_max_delta: got %0d required 0", max_delta); else passes++;
    model_sweep(2, 20);
    check_model("uni");
  endtask

  task automatic test_zero_iter();
    int lat;
    run(0, 3, 5, 0, lat);
    checks++;
    if (lat !== 1) $display("FAIL zero_latency: got %0d required 1", lat); else passes++;
    checks++;
    if (sweep_count !== 8'd0) $display("FAIL zero_sweeps: got %0d required 0", sweep_count); else passes++;
    checks++;
    if (converged !== 1'b0) $display("FAIL zero_converged: got %0b required 0", converged); else passes++;
    check_model("zero");
  endtask

  task automatic test_boundary_heat();
    int lat;
    int regress;
    int prev[N];
    for (int i = 0; i < N; i++) model[i] = 0;
    load_model();
    run(3, 1, 40, 0, lat);
    checks++;
    if (lat !== 3 * (N + 1) + 1) $display("FAIL heat_latency: got %0d required %0d", lat, 3 * (N + 1) + 1);
    else passes++;
    checks++;
    if (sweep_count !== 8'd3) $display("FAIL heat_sweeps: got %0d required 3", sweep_count); else passes++;
    checks++;
    if (converged !== 1'b0) $display("FAIL heat_converged: got %0b required 0", converged); else passes++;
    regress = 0;
    for (int s = 0; s < 3; s++) begin
      prev = model;
      model_sweep(1, 40);
      for (int i = 0; i < N; i++) if (model[i] < prev[i]) regress++;
    end
    checks++;
    if (max_delta !== TW'(model_max)) $display("FAIL heat_max_delta: got %0d required %0d", max_delta, model_max);
    else passes++;
    checks++;
    if (regress != 0) $display("FAIL heat_monotone: %0d reference cells decreased, required 0", regress);
    else passes++;
    check_model("heat");
  endtask

  task automatic test_mid_run();
    int    cyc;
    int    seen;
    int    e;
    int    bad_done;
    string t;
    for (int i = 0; i < N; i++) model[i] = 0;
    load_model();
    iterations = 8'd200; alpha = 2'd3; boundary = 6'd33; eps = 6'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    seen = -1;
    while (cyc < 300 && seen < 0) begin
      if (cyc == 10) begin
        host_we = 1'b1; host_addr = AW'(20); host_wdata = 6'd7;
      end else begin
        host_we = 1'b0;
      end
      if (cyc == 11) begin
        name_q.push_back("mid_dropped_write");
        exp_q.push_back(0);
        host_addr = AW'(20);
      end
      start = (cyc == 20);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 12) begin
        t = name_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (host_rdata !== TW'(e)) $display("FAIL %s: host_rdata=%0d expected %0d", t, host_rdata, e);
        else passes++;
      end
      if (sweep_count === 8'd1 && seen < 0) seen = cyc;
    end
    start = 1'b0;
    checks++;
    if (seen !== N + 1) $display("FAIL mid_first_swap: at cycle %0d required %0d", seen, N + 1); else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy: got %0b required 1", busy); else passes++;
    read_cell(19, 0, "mid_neighbour19");
    read_cell(0, 33, "mid_edge0");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, converged, sweep_count, max_delta, host_rdata} !== '0)
      $display("FAIL mid_async_reset: busy=%0b done=%0b conv=%0b sweeps=%0d maxd=%0d rdata=%0d required all 0",
               busy, done, converged, sweep_count, max_delta, host_rdata);
    else passes++;
    bad_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_done != 0) $display("FAIL mid_no_done: %0d cycles with done/busy high, required 0", bad_done);
    else passes++;
    read_cell(0, 0, "mid_cleared_edge0");
    read_cell(27, 0, "mid_cleared_cell27");
  endtask

  initial begin
    test_reset();
    test_single_hot();
    test_uniform();
    test_zero_iter();
    test_boundary_heat();
    test_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
